// File: rtl/task_regfile.sv
// Two-bank register file with per-task PC/QP and same-cycle write bypass on the read ports.
// All updates land one edge after the strobe; the block is always ready and takes every strobe at its edge.
module task_regfile #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] RESET_QP = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] wb_result,
  input  logic        wb_ws_reg,
  input  logic        wb_ws_pc,
  input  logic        wb_ws_qp,
  input  logic        wb_ts,
  input  logic [3:0]  wb_sel_rd,
  input  logic        rd_ts,
  input  logic [3:0]  rd_sel_a,
  input  logic [3:0]  rd_sel_b,
  output logic [15:0] rd_a,
  output logic [15:0] rd_b,
  input  logic        pc_ts,
  input  logic        pc_adv,
  input  logic        qp_inc,
  input  logic        qp_dec,
  output logic [15:0] pc_out,
  output logic [15:0] qp_out,
  output logic [7:0]  wb_count
);

  logic [15:0] regs [2][16];
  logic [15:0] pc   [2];
  logic [15:0] qp   [2];
  logic [7:0]  count;

  logic any_wb;
  assign any_wb = wb_ws_reg | wb_ws_pc | wb_ws_qp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < 2; t++) begin
        for (int i = 0; i < 16; i++) begin
          regs[t][i] <= '0;
        end
        pc[t] <= RESET_PC;
        qp[t] <= RESET_QP;
      end
      count <= '0;
    end else begin
      if (wb_ws_reg) begin
        regs[wb_ts][wb_sel_rd] <= wb_result;
      end
      for (int t = 0; t < 2; t++) begin
        // A writeback to the same task overrides any local advance.
        if (wb_ws_pc && (wb_ts == t[0])) begin
          pc[t] <= wb_result;
        end else if (pc_adv && (pc_ts == t[0])) begin
          pc[t] <= pc[t] + 16'd1;
        end

        if (wb_ws_qp && (wb_ts == t[0])) begin
          qp[t] <= wb_result;
        end else if (pc_ts == t[0]) begin
          if (qp_inc && !qp_dec) begin
            qp[t] <= qp[t] + 16'd1;
          end else if (qp_dec && !qp_inc) begin
            qp[t] <= qp[t] - 16'd1;
          end
        end
      end
      if (any_wb) begin
        count <= count + 8'd1;
      end
    end
  end

  // Write-first bypass so operand fetch sees the value being committed this cycle.
  assign rd_a = (wb_ws_reg && (wb_ts == rd_ts) && (wb_sel_rd == rd_sel_a)) ? wb_result
                                                                            : regs[rd_ts][rd_sel_a];
  assign rd_b = (wb_ws_reg && (wb_ts == rd_ts) && (wb_sel_rd == rd_sel_b)) ? wb_result
                                                                            : regs[rd_ts][rd_sel_b];

  assign pc_out   = pc[pc_ts];
  assign qp_out   = qp[pc_ts];
  assign wb_count = count;

endmodule

// File: tb/tb_task_regfile.sv
// Directed bench for task_regfile with RESET_PC = 16'h0100.
module tb_task_regfile;

  logic        clk;
  logic        rst_n;
  logic [15:0] wb_result;
  logic        wb_ws_reg;
  logic        wb_ws_pc;
  logic        wb_ws_qp;
  logic        wb_ts;
  logic [3:0]  wb_sel_rd;
  logic        rd_ts;
  logic [3:0]  rd_sel_a;
  logic [3:0]  rd_sel_b;
  logic [15:0] rd_a;
  logic [15:0] rd_b;
  logic        pc_ts;
  logic        pc_adv;
  logic        qp_inc;
  logic        qp_dec;
  logic [15:0] pc_out;
  logic [15:0] qp_out;
  logic [7:0]  wb_count;

  int checks   = 0;
  int failures = 0;

  task_regfile #(.RESET_PC(16'h0100), .RESET_QP(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_result(wb_result), .wb_ws_reg(wb_ws_reg), .wb_ws_pc(wb_ws_pc), .wb_ws_qp(wb_ws_qp),
    .wb_ts(wb_ts), .wb_sel_rd(wb_sel_rd),
    .rd_ts(rd_ts), .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b), .rd_a(rd_a), .rd_b(rd_b),
    .pc_ts(pc_ts), .pc_adv(pc_adv), .qp_inc(qp_inc), .qp_dec(qp_dec),
    .pc_out(pc_out), .qp_out(qp_out), .wb_count(wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are changed and outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_ws_reg = 0; wb_ws_pc = 0; wb_ws_qp = 0;
    pc_adv = 0; qp_inc = 0; qp_dec = 0;
  endtask

  initial begin
    rst_n = 0; wb_result = '0; wb_ts = 0; wb_sel_rd = '0;
    rd_ts = 0; rd_sel_a = 4'd5; rd_sel_b = 4'd6; pc_ts = 0;
    idle();

    // Reset state
    #12;
    chk("rst_pc0", pc_out, 16'h0100);
    chk("rst_qp0", qp_out, 16'h0000);
    chk("rst_rd_a", rd_a, 16'h0000);
    chk("rst_rd_b", rd_b, 16'h0000);
    chk("rst_count", {8'h00, wb_count}, 16'h0000);
    pc_ts = 1; #1;
    chk("rst_pc1", pc_out, 16'h0100);
    pc_ts = 0;
    @(negedge clk); rst_n = 1;
    tick();

    // Bank isolation and bypass
    wb_ws_reg = 1; wb_ts = 0; wb_sel_rd = 4'd5; wb_result = 16'hBEEF;
    rd_ts = 0; rd_sel_a = 4'd5; rd_sel_b = 4'd6; #1;
    chk("byp_t0_a", rd_a, 16'hBEEF);
    chk("nobyp_t0_b", rd_b, 16'h0000);
    tick();
    wb_ts = 1; wb_result = 16'h1234; rd_ts = 1; rd_sel_a = 4'd5; rd_sel_b = 4'd5; #1;
    chk("byp_t1_a", rd_a, 16'h1234);
    chk("byp_t1_b", rd_b, 16'h1234);
    tick();
    wb_ts = 0; wb_sel_rd = 4'd6; wb_result = 16'h5555; rd_ts = 1; rd_sel_a = 4'd6; #1;
    chk("nobyp_othertask", rd_a, 16'h0000);
    tick();
    idle(); rd_ts = 0; rd_sel_a = 4'd5; rd_sel_b = 4'd6; #1;
    chk("reg_t0_r5", rd_a, 16'hBEEF);
    chk("reg_t0_r6", rd_b, 16'h5555);
    rd_ts = 1; #1;
    chk("reg_t1_r5", rd_a, 16'h1234);
    chk("reg_t1_r6", rd_b, 16'h0000);

    // Branch priority
    wb_ws_pc = 1; wb_ts = 0; wb_result = 16'h0010; pc_ts = 0;
    tick();
    idle(); chk("pc0_load", pc_out, 16'h0010);
    wb_ws_pc = 1; wb_ts = 0; wb_result = 16'h0400; pc_adv = 1; pc_ts = 0;
    tick();
    idle(); chk("branch_wins", pc_out, 16'h0400);

    // Cross-task independence
    wb_ws_pc = 1; wb_ts = 0; wb_result = 16'h0777; pc_adv = 1; pc_ts = 1;
    tick();
    idle(); pc_ts = 0; #1;
    chk("cross_pc0", pc_out, 16'h0777);
    pc_ts = 1; #1;
    chk("cross_pc1", pc_out, 16'h0101);

    // PC wrap on task 1
    wb_ws_pc = 1; wb_ts = 1; wb_result = 16'hFFFF;
    tick();
    idle(); chk("pc1_ffff", pc_out, 16'hFFFF);
    pc_adv = 1;
    tick();
    idle(); chk("pc1_wrap", pc_out, 16'h0000);

    // QP on task 0
    pc_ts = 0; qp_dec = 1;
    tick();
    idle(); chk("qp_dec_wrap", qp_out, 16'hFFFF);
    pc_ts = 1; #1;
    chk("qp1_untouched", qp_out, 16'h0000);
    pc_ts = 0; qp_inc = 1; qp_dec = 1;
    tick();
    idle(); chk("qp_incdec_hold", qp_out, 16'hFFFF);
    qp_inc = 1;
    tick();
    idle(); chk("qp_inc_wrap", qp_out, 16'h0000);
    qp_inc = 1;
    tick();
    idle(); chk("qp_inc", qp_out, 16'h0001);
    wb_ws_qp = 1; wb_ts = 0; wb_result = 16'h2A2A; qp_inc = 1;
    tick();
    idle(); chk("qp_load_wins", qp_out, 16'h2A2A);
    chk("count_8", {8'h00, wb_count}, 16'h0008);

    // Mid-operation reset drops the in-flight strobe and clears state
    @(negedge clk);
    wb_ws_reg = 1; wb_ts = 0; wb_sel_rd = 4'd7; wb_result = 16'hDEAD;
    rst_n = 0; #1;
    idle(); rst_n = 0;
    #2;
    rd_ts = 0; rd_sel_a = 4'd5; rd_sel_b = 4'd7; pc_ts = 0; #1;
    chk("rst2_rd_a", rd_a, 16'h0000);
    chk("rst2_rd_b", rd_b, 16'h0000);
    chk("rst2_pc0", pc_out, 16'h0100);
    chk("rst2_qp0", qp_out, 16'h0000);
    chk("rst2_count", {8'h00, wb_count}, 16'h0000);
    @(negedge clk); rst_n = 1;
    tick();

    // Counter wrap
    wb_ws_reg = 1; wb_ts = 1; wb_sel_rd = 4'd0; wb_result = 16'h0001;
    for (int i = 0; i < 255; i++) tick();
    chk("count_255", {8'h00, wb_count}, 16'h00FF);
    tick();
    chk("count_wrap", {8'h00, wb_count}, 16'h0000);
    tick();
    idle(); chk("count_257", {8'h00, wb_count}, 16'h0001);
    tick();
    chk("count_idle", {8'h00, wb_count}, 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/task_regfile.md
# task_regfile

Writeback-side register file for the two-task core. It sits directly downstream of the ALU and consumes its `result`, `ws_pc`, `ws_reg`, `ws_qp`, `o_ts` and `o_sel_rd` outputs. It holds two banks (task 0 and task 1) of 16 general registers, one program counter and one queue pointer per task. It also serves the operand-fetch stage upstream of the ALU through two combinational read ports with same-cycle write bypass.

## Interface
- `RESET_PC`, default 16'h0000: reset value of both task PCs.
- `RESET_QP`, default 16'h0000: reset value of both task QPs.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `wb_result`  in  16  ALU result to write back.
- `wb_ws_reg`  in  1  write `wb_result` to general register `wb_sel_rd` of task `wb_ts`.
- `wb_ws_pc`  in  1  write `wb_result` to PC of task `wb_ts`.
- `wb_ws_qp`  in  1  write `wb_result` to QP of task `wb_ts`.
- `wb_ts`  in  1  task selector of the writeback.
- `wb_sel_rd`  in  4  destination register index.
- `rd_ts`  in  1  task selector for operand reads.
- `rd_sel_a`, `rd_sel_b`  in  4 each  read indices.
- `rd_a`, `rd_b`  out  16 each  operand values.
- `pc_ts`  in  1  task whose PC/QP are presented and advanced.
- `pc_adv`  in  1  fetch consumed one word; PC of `pc_ts` += 1.
- `qp_inc`  in  1  QP of `pc_ts` += 1.
- `qp_dec`  in  1  QP of `pc_ts` -= 1.
- `pc_out`, `qp_out`  out  16 each  current PC/QP of task `pc_ts`.
- `wb_count`  out  8  count of committed writebacks; wraps.

## Operation
- Storage: 2×16×16 general registers, 2 PCs, 2 QPs, one 8-bit counter.
- Reset, asynchronous on `rst_n` low:
  - all general registers clear to 0.
  - PCs load `RESET_PC`; QPs load `RESET_QP`.
  - `wb_count` clears to 0.
  - Outputs then reflect the reset state combinationally.
- All 16 registers are writable. There is no hardwired zero.
- General write: when `wb_ws_reg`=1, register[`wb_ts`][`wb_sel_rd`] <= `wb_result` at the edge.
- PC update, per task, in priority order:
  1. If `wb_ws_pc` and `wb_ts` select this task, load `wb_result`. Any `pc_adv` for the same task in that cycle is discarded (branch wins).
  2. Else if `pc_adv` and `pc_ts` select this task, PC <= PC+1, mod 2^16 (16'hFFFF → 16'h0000).
- QP update, per task, in priority order:
  1. If `wb_ws_qp` and `wb_ts` select this task, load `wb_result`. Any inc/dec for the same task is discarded.
  2. Else if `qp_inc` and `qp_dec` are both 1: no change.
  3. Else if only `qp_inc`: +1, mod 2^16.
  4. Else if only `qp_dec`: −1, mod 2^16 (16'h0000 → 16'hFFFF).
- Updates to different tasks in the same cycle are independent and both take effect.
- The `ws_*` strobes are decoded from a 2-bit select, so at most one is high. If several are high, each applies independently.
- `wb_count` increments by 1 on every edge where any of `wb_ws_reg`/`wb_ws_pc`/`wb_ws_qp` is 1. It wraps at 255 → 0.
- Read ports, combinational:
  - `rd_a` = register[`rd_ts`][`rd_sel_a`]; `rd_b` likewise with `rd_sel_b`.
  - Bypass: if `wb_ws_reg`=1, `wb_ts`==`rd_ts` and `wb_sel_rd`==index, the port returns `wb_result` (write-first).
  - Each port bypasses independently; both may bypass at once.
- `pc_out`/`qp_out` show registered state only, with no bypass of `wb_result`.

## Timing
- Write latency: visible in registered state one edge after the strobe. Through the bypass, visible on the read ports in the same cycle.
- `pc_out`/`qp_out` reflect an update one edge after the update condition.
- No handshakes. The block is always ready, and every strobe is consumed at its edge.
- Reset deasserted between edges: the first edge after release performs a normal update.
- Reset asserted mid-operation: any in-flight strobe is lost. No partial writes.

## Test plan
- Reset state: assert `rst_n`=0 with `RESET_PC`=16'h0100 → both PCs read 16'h0100, QPs 16'h0000, `rd_a`=`rd_b`=0, `wb_count`=0.
- Bank isolation and bypass:
  - Write 16'hBEEF to task0 r5, then 16'h1234 to task1 r5.
  - Reading task0 r5 returns 16'hBEEF; task1 r5 returns 16'h1234.
  - During the task1 write cycle, `rd_ts`=1, `rd_sel_a`=5 already shows 16'h1234.
- Branch priority: task0 PC=16'h0010; same cycle `pc_adv`=1, `wb_ws_pc`=1, `wb_result`=16'h0400 → PC=16'h0400, not 16'h0011.
- Cross-task independence: `pc_adv` for task1 while `wb_ws_pc` targets task0 → task0 PC loads, task1 PC increments.
- Wrap:
  - PC=16'hFFFF + `pc_adv` → 16'h0000.
  - QP=16'h0000 + `qp_dec` → 16'hFFFF.
  - `qp_inc`+`qp_dec` together → unchanged.
  - `wb_ws_qp` with `qp_inc` → loads `wb_result`.
- Counter: 256 consecutive `wb_ws_reg` strobes from reset → `wb_count`=0 after wrap, 1 after the 257th.
